// File: rtl/instruction_fetch.sv
// ============================================================================
// instruction_fetch
//
// Purpose:
//   Fetch unit between the PC/branch logic and the decoder. It owns the
//   program counter, drives the word address of a registered-read instruction
//   memory (one cycle of read latency), and turns the returning data into a
//   valid/ready instruction stream. Up to two fetches run ahead of the
//   decoder. Returned words land in a 2-entry response buffer, and a credit
//   check stops issue before that buffer can overflow. A single-cycle
//   redirect flushes everything and restarts fetch at a new address.
//
// Parameters:
//   ADDR_WIDTH  width of the memory word address and of every PC value
//   DATA_WIDTH  instruction width
//   RESET_PC    fetch address loaded by reset
//
// Ports:
//   i_clk            rising-edge clock
//   i_rst            synchronous, active-high reset
//   o_imem_addr      word address to instruction_memory.addr (registered)
//   i_imem_instruct  instruction_memory.instruct; holds mem[addr of prev edge]
//   o_instr          head instruction (registered)
//   o_instr_pc       address of o_instr (registered)
//   o_instr_valid    o_instr / o_instr_pc are valid
//   i_instr_ready    decoder accepts; handshake when valid && ready at an edge
//   i_redirect       single-cycle pulse: restart fetch at i_redirect_pc
//   i_redirect_pc    new fetch address, sampled while i_redirect is high
//   o_stall_cycles   count of edges with valid && !ready, saturating
//                    (present only when IFETCH_STALL_CNT_EN is defined)
//
// Configuration macro:
//   IFETCH_STALL_CNT_EN  adds the o_stall_cycles port and its counter.
//                        Without it the port and counter are absent and all
//                        other behaviour is identical.
// ============================================================================
module instruction_fetch #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  input  logic [DATA_WIDTH-1:0] i_imem_instruct,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0] o_instr_pc,
  output logic                  o_instr_valid,
  input  logic                  i_instr_ready,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [31:0]           o_stall_cycles
`endif
);

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic                  r_req_valid;
  logic [ADDR_WIDTH-1:0] r_req_pc;
  logic [DATA_WIDTH-1:0] r_buf_instr [2];
  logic [ADDR_WIDTH-1:0] r_buf_pc    [2];
  logic [1:0]            r_count;

  // Next-state values
  logic [ADDR_WIDTH-1:0] w_fetch_pc_nxt;
  logic                  w_req_valid_nxt;
  logic [ADDR_WIDTH-1:0] w_req_pc_nxt;
  logic [DATA_WIDTH-1:0] w_buf_instr_nxt [2];
  logic [ADDR_WIDTH-1:0] w_buf_pc_nxt    [2];
  logic [1:0]            w_count_nxt;

  // Per-edge events
  logic       w_pop;
  logic       w_push;
  logic [2:0] w_credit;
  logic       w_issue;

  // --------------------------------------------------------------------------
  // Handshake, push and issue decisions.
  // Buffer entry 0 is always the head; the buffer shifts toward entry 0 on a
  // pop. w_credit is the number of slots that would still be claimed after
  // this edge (buffered words + the word in flight - the word leaving). A new
  // fetch is only started while fewer than two slots are claimed, so the
  // response it produces next cycle always has a free slot to land in.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pop    = (r_count != 2'd0) && i_instr_ready;
    w_push   = r_req_valid;
    w_credit = {1'b0, r_count} + {2'b00, r_req_valid} - {2'b00, w_pop};
    w_issue  = (w_credit < 3'd2);
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Redirect outranks everything: the buffer is emptied,
  // the word in flight is dropped (it belongs to the old path) and fetch
  // restarts at the redirect target. A handshake at the same edge has already
  // consumed the head, so there is nothing further to do for it. Otherwise
  // the fetch side and the buffer side are updated independently.
  // --------------------------------------------------------------------------
  always_comb begin
    w_fetch_pc_nxt     = r_fetch_pc;
    w_req_valid_nxt    = 1'b0;
    w_req_pc_nxt       = r_req_pc;
    w_buf_instr_nxt[0] = r_buf_instr[0];
    w_buf_instr_nxt[1] = r_buf_instr[1];
    w_buf_pc_nxt[0]    = r_buf_pc[0];
    w_buf_pc_nxt[1]    = r_buf_pc[1];
    w_count_nxt        = r_count;

    if (i_redirect) begin
      w_fetch_pc_nxt  = i_redirect_pc;
      w_req_valid_nxt = 1'b0;
      w_count_nxt     = 2'd0;
    end else begin
      // Fetch side: the PC wraps naturally at the top of the address space.
      if (w_issue) begin
        w_req_pc_nxt    = r_fetch_pc;
        w_req_valid_nxt = 1'b1;
        w_fetch_pc_nxt  = r_fetch_pc + ADDR_WIDTH'(1);
      end

      // Buffer side.
      case ({w_push, w_pop})
        2'b01: begin
          w_buf_instr_nxt[0] = r_buf_instr[1];
          w_buf_pc_nxt[0]    = r_buf_pc[1];
          w_count_nxt        = r_count - 2'd1;
        end
        2'b10: begin
          if (r_count == 2'd0) begin
            w_buf_instr_nxt[0] = i_imem_instruct;
            w_buf_pc_nxt[0]    = r_req_pc;
          end else begin
            w_buf_instr_nxt[1] = i_imem_instruct;
            w_buf_pc_nxt[1]    = r_req_pc;
          end
          w_count_nxt = r_count + 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word goes behind whatever remains.
          if (r_count == 2'd1) begin
            w_buf_instr_nxt[0] = i_imem_instruct;
            w_buf_pc_nxt[0]    = r_req_pc;
          end else begin
            w_buf_instr_nxt[0] = r_buf_instr[1];
            w_buf_pc_nxt[0]    = r_buf_pc[1];
            w_buf_instr_nxt[1] = i_imem_instruct;
            w_buf_pc_nxt[1]    = r_req_pc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State register. Reset clears the buffer contents as well, so the head
  // outputs read zero until the first instruction arrives.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_pc     <= RESET_PC;
      r_req_valid    <= 1'b0;
      r_req_pc       <= '0;
      r_buf_instr[0] <= '0;
      r_buf_instr[1] <= '0;
      r_buf_pc[0]    <= '0;
      r_buf_pc[1]    <= '0;
      r_count        <= 2'd0;
    end else begin
      r_fetch_pc     <= w_fetch_pc_nxt;
      r_req_valid    <= w_req_valid_nxt;
      r_req_pc       <= w_req_pc_nxt;
      r_buf_instr[0] <= w_buf_instr_nxt[0];
      r_buf_instr[1] <= w_buf_instr_nxt[1];
      r_buf_pc[0]    <= w_buf_pc_nxt[0];
      r_buf_pc[1]    <= w_buf_pc_nxt[1];
      r_count        <= w_count_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs come straight from registers.
  // --------------------------------------------------------------------------
  always_comb begin
    o_imem_addr   = r_fetch_pc;
    o_instr       = r_buf_instr[0];
    o_instr_pc    = r_buf_pc[0];
    o_instr_valid = (r_count != 2'd0);
  end

`ifdef IFETCH_STALL_CNT_EN
  // --------------------------------------------------------------------------
  // Stall counter: counts edges where the decoder holds off a valid head.
  // Only reset clears it; a redirect leaves it alone. It sticks at all-ones.
  // --------------------------------------------------------------------------
  logic [31:0] r_stall_cycles;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cycles <= '0;
    end else if (o_instr_valid && !i_instr_ready && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// tb_instruction_fetch
//
// Directed bench for instruction_fetch. Two instances share clock and reset:
// dut0 uses RESET_PC = 0 and is exercised through every scenario; dut1 uses
// RESET_PC = 16'hFFFE with ready tied high to cover PC wrap-around. Each has
// its own registered-read memory model holding mem[i] = 16'hA000 + i.
// Inputs change 1 time unit after each rising edge and outputs are checked
// at the same point, i.e. well away from the active edge.
// ============================================================================
module tb_instruction_fetch;

  logic        clk;
  logic        rst;

  logic [15:0] imemAddr0;
  logic [15:0] imemData0;
  logic [15:0] instr0;
  logic [15:0] instrPc0;
  logic        instrValid0;
  logic        ready0;
  logic        redirect0;
  logic [15:0] redirectPc0;

  logic [15:0] imemAddr1;
  logic [15:0] imemData1;
  logic [15:0] instr1;
  logic [15:0] instrPc1;
  logic        instrValid1;
  logic        ready1;
  logic        redirect1;
  logic [15:0] redirectPc1;

`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stallCycles0;
  logic [31:0] stallCycles1;
`endif

  int testsRun;
  int testsFailed;

  instruction_fetch #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (16),
    .RESET_PC   (16'h0000)
  ) dut0 (
    .i_clk           (clk),
    .i_rst           (rst),
    .o_imem_addr     (imemAddr0),
    .i_imem_instruct (imemData0),
    .o_instr         (instr0),
    .o_instr_pc      (instrPc0),
    .o_instr_valid   (instrValid0),
    .i_instr_ready   (ready0),
    .i_redirect      (redirect0),
    .i_redirect_pc   (redirectPc0)
`ifdef IFETCH_STALL_CNT_EN
    ,
    .o_stall_cycles  (stallCycles0)
`endif
  );

  instruction_fetch #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (16),
    .RESET_PC   (16'hFFFE)
  ) dut1 (
    .i_clk           (clk),
    .i_rst           (rst),
    .o_imem_addr     (imemAddr1),
    .i_imem_instruct (imemData1),
    .o_instr         (instr1),
    .o_instr_pc      (instrPc1),
    .o_instr_valid   (instrValid1),
    .i_instr_ready   (ready1),
    .i_redirect      (redirect1),
    .i_redirect_pc   (redirectPc1)
`ifdef IFETCH_STALL_CNT_EN
    ,
    .o_stall_cycles  (stallCycles1)
`endif
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read instruction memories: mem[i] = 16'hA000 + i (16-bit wrap).
  always_ff @(posedge clk) begin
    imemData0 <= 16'(16'hA000 + imemAddr0);
    imemData1 <= 16'(16'hA000 + imemAddr1);
  end

  // Advance into the next cycle, landing 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the decoder-side inputs of dut0 for the current cycle.
  task automatic applyStimulus(input logic rdy, input logic redir, input logic [15:0] rpc);
    ready0      = rdy;
    redirect0   = redir;
    redirectPc0 = rpc;
  endtask

  // One comparison: count it, and on mismatch count and report it.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Startup sequence of dut0 with ready held high, starting in cycle 0.
  // Ends in cycle 4.
  task automatic checkStartup(input string phase);
    checkOutput({phase, "_c0_addr"},  32'(imemAddr0),   32'h0000);
    checkOutput({phase, "_c0_valid"}, 32'(instrValid0), 32'h0);
    checkOutput({phase, "_c0_instr"}, 32'(instr0),      32'h0000);
    checkOutput({phase, "_c0_pc"},    32'(instrPc0),    32'h0000);
`ifdef IFETCH_STALL_CNT_EN
    checkOutput({phase, "_c0_stall"}, stallCycles0,     32'd0);
`endif
    tick();
    checkOutput({phase, "_c1_valid"}, 32'(instrValid0), 32'h0);
    checkOutput({phase, "_c1_addr"},  32'(imemAddr0),   32'h0001);
    tick();
    checkOutput({phase, "_c2_valid"}, 32'(instrValid0), 32'h1);
    checkOutput({phase, "_c2_instr"}, 32'(instr0),      32'hA000);
    checkOutput({phase, "_c2_pc"},    32'(instrPc0),    32'h0000);
    tick();
    checkOutput({phase, "_c3_valid"}, 32'(instrValid0), 32'h1);
    checkOutput({phase, "_c3_instr"}, 32'(instr0),      32'hA001);
    checkOutput({phase, "_c3_pc"},    32'(instrPc0),    32'h0001);
    tick();
    checkOutput({phase, "_c4_valid"}, 32'(instrValid0), 32'h1);
    checkOutput({phase, "_c4_instr"}, 32'(instr0),      32'hA002);
    checkOutput({phase, "_c4_pc"},    32'(instrPc0),    32'h0002);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    ready1      = 1'b1;
    redirect1   = 1'b0;
    redirectPc1 = 16'h0000;
    applyStimulus(1'b1, 1'b0, 16'h0000);

    // ---------------- Phase A: reset release, streaming, wrap on dut1 -------
    tick();
    tick();
    rst = 1'b0;
    // cycle 0
    checkOutput("wrap_c0_addr", 32'(imemAddr1), 32'hFFFE);
    checkOutput("wrap_c0_valid", 32'(instrValid1), 32'h0);
    fork
      checkStartup("start");
      begin
        // dut1 runs in lockstep; its checks for cycles 2..4 go here.
        tick();
        tick();
        checkOutput("wrap_c2_instr", 32'(instr1),   32'h9FFE);
        checkOutput("wrap_c2_pc",    32'(instrPc1), 32'hFFFE);
        tick();
        checkOutput("wrap_c3_instr", 32'(instr1),   32'h9FFF);
        checkOutput("wrap_c3_pc",    32'(instrPc1), 32'hFFFF);
        tick();
        checkOutput("wrap_c4_instr", 32'(instr1),   32'hA000);
        checkOutput("wrap_c4_pc",    32'(instrPc1), 32'h0000);
      end
    join
    // cycle 5
    tick();
    checkOutput("wrap_c5_valid", 32'(instrValid1), 32'h1);
    checkOutput("wrap_c5_instr", 32'(instr1),      32'hA001);
    checkOutput("wrap_c5_pc",    32'(instrPc1),    32'h0001);

    // ---------------- Phase B: reset mid-stream with buffer full ------------
    applyStimulus(1'b0, 1'b0, 16'h0000);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkStartup("rstmid");

    // ---------------- Phase C: decoder stalls from cycle 2 for 5 cycles -----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    for (int k = 2; k <= 6; k++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000);
      checkOutput($sformatf("stall_c%0d_valid", k), 32'(instrValid0), 32'h1);
      checkOutput($sformatf("stall_c%0d_instr", k), 32'(instr0),      32'hA000);
      checkOutput($sformatf("stall_c%0d_pc", k),    32'(instrPc0),    32'h0000);
      checkOutput($sformatf("stall_c%0d_addr", k),  32'(imemAddr0),   32'h0002);
      tick();
    end
    // cycle 7: ready rises
    applyStimulus(1'b1, 1'b0, 16'h0000);
`ifdef IFETCH_STALL_CNT_EN
    checkOutput("stall_count5", stallCycles0, 32'd5);
`endif
    checkOutput("resume_c7_instr", 32'(instr0),   32'hA000);
    checkOutput("resume_c7_pc",    32'(instrPc0), 32'h0000);
    tick();
    checkOutput("resume_c8_valid", 32'(instrValid0), 32'h1);
    checkOutput("resume_c8_instr", 32'(instr0),      32'hA001);
    checkOutput("resume_c8_pc",    32'(instrPc0),    32'h0001);
    tick();
    checkOutput("resume_c9_valid", 32'(instrValid0), 32'h1);
    checkOutput("resume_c9_instr", 32'(instr0),      32'hA002);
    checkOutput("resume_c9_pc",    32'(instrPc0),    32'h0002);

    // ---------------- Phase D: redirect while ready toggles -----------------
    tick();
    // cycle 10: one more stalled edge
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("redir_c10_instr", 32'(instr0), 32'hA003);
    tick();
    // cycle 11: redirect together with a handshake
    applyStimulus(1'b1, 1'b1, 16'h0040);
`ifdef IFETCH_STALL_CNT_EN
    checkOutput("redir_stall_before", stallCycles0, 32'd6);
`endif
    tick();
    // cycle 12
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("redir_n1_valid", 32'(instrValid0), 32'h0);
    checkOutput("redir_n1_addr",  32'(imemAddr0),   32'h0040);
    tick();
    // cycle 13
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("redir_n2_valid", 32'(instrValid0), 32'h0);
    checkOutput("redir_n2_addr",  32'(imemAddr0),   32'h0041);
    tick();
    // cycle 14
    checkOutput("redir_n3_valid", 32'(instrValid0), 32'h1);
    checkOutput("redir_n3_instr", 32'(instr0),      32'hA040);
    checkOutput("redir_n3_pc",    32'(instrPc0),    32'h0040);
    tick();
    // cycle 15
    checkOutput("redir_n4_valid", 32'(instrValid0), 32'h1);
    checkOutput("redir_n4_instr", 32'(instr0),      32'hA041);
    checkOutput("redir_n4_pc",    32'(instrPc0),    32'h0041);
`ifdef IFETCH_STALL_CNT_EN
    checkOutput("redir_stall_kept", stallCycles0, 32'd6);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit that drives the address side of `instruction_memory` and turns its one-cycle-latency read data into a valid/ready instruction stream for decode. It holds the program counter, runs up to two fetches ahead using a 2-entry response buffer, and accepts single-cycle redirects from branch/jump resolution. It sits between the PC/branch logic and the decoder.

## Interface
- `ADDR_WIDTH`, 16, width of the word address to instruction memory and of all PC values.
- `DATA_WIDTH`, 16, instruction width.
- `RESET_PC`, 0, PC loaded on reset.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_addr`  out  ADDR_WIDTH  word address to `instruction_memory.addr`.
- `imem_instruct`  in  DATA_WIDTH  `instruction_memory.instruct`; holds mem[addr sampled at the previous edge].
- `instr`  out  DATA_WIDTH  head instruction.
- `instr_pc`  out  ADDR_WIDTH  address of `instr`.
- `instr_valid`  out  1  `instr`/`instr_pc` are valid.
- `instr_ready`  in  1  decoder accepts; handshake when valid && ready at an edge.
- `redirect`  in  1  single-cycle pulse: restart fetch at `redirect_pc`.
- `redirect_pc`  in  ADDR_WIDTH  new fetch address, sampled when `redirect` is high.
- `stall_cycles`  out  32  present only with `IFETCH_STALL_CNT_EN`.

## Operation
- State: `fetch_pc`, which drives `imem_addr` directly as a register. In-flight flag `req_valid` plus `req_pc`. 2-entry FIFO of {instr, pc}, `count` in 0..2.
- Issue at an edge when `(count + req_valid - pop) < 2`, where pop = valid && ready. On issue, `req_pc <= fetch_pc`, `req_valid <= 1`, and `fetch_pc <= fetch_pc + 1` modulo 2^ADDR_WIDTH, so all-ones wraps to 0. Without issue, `req_valid <= 0` and `fetch_pc` holds.
- When `req_valid` is set at an edge, push {`imem_instruct`, `req_pc`} into the FIFO.
- Push and pop at the same edge: occupancy is unchanged and order is preserved. The credit rule guarantees a push never meets a full FIFO.
- `instr`/`instr_pc`/`instr_valid` reflect the FIFO head, driven from registers. `instr_valid = (count != 0)`.
- Redirect has priority over issue, push and grow. A handshake at the same edge still counts as consumed. At that edge: FIFO emptied, `req_valid <= 0` (in-flight response discarded), `fetch_pc <= redirect_pc`.
- Reset, at any edge, in any state: `fetch_pc = RESET_PC`, `req_valid = 0`, `count = 0`.
- Reset values: `imem_addr = RESET_PC`, `instr = 0`, `instr_pc = 0`, `instr_valid = 0`, `stall_cycles = 0`.

## Timing
- Cycle 0 is the first cycle with `rst` low. `imem_addr = RESET_PC` in cycle 0, and the first issue happens at the end of cycle 0.
- Cycle 1: `imem_instruct = mem[RESET_PC]`.
- Cycle 2: `instr_valid = 1`, `instr = mem[RESET_PC]`, `instr_pc = RESET_PC`. Fetch-to-valid latency is 2 cycles.
- With `instr_ready` held high: one instruction per cycle from cycle 2, PCs consecutive.
- `instr_ready` low: at most 2 further issues complete, then `imem_addr` freezes. Head is stable while `instr_valid && !instr_ready`.
- Redirect at the edge ending cycle N: `instr_valid = 0` in cycle N+1 and N+2. The first `redirect_pc` instruction is valid in cycle N+3.

## Configuration
- `IFETCH_STALL_CNT_EN` defined: port `stall_cycles` exists.
  - Increments at each edge where `instr_valid && !instr_ready`, saturating at 32'hFFFF_FFFF.
  - Cleared by `rst` only; redirect does not clear it.
- Undefined: port and counter absent. All other behaviour is identical.

## Test plan
Memory model: registered read, mem[i] = 16'hA000 + i.
- Reset release, `instr_ready` = 1 → cycle 2 shows instr 16'hA000 / pc 0, cycle 3 shows 16'hA001 / pc 1, cycle 4 shows 16'hA002 / pc 2, valid every cycle.
- `instr_ready` = 0 from cycle 2 for 5 cycles → instr stays 16'hA000, `imem_addr` stops at 2. After ready rises: 16'hA000, 16'hA001, 16'hA002 on consecutive cycles, none dropped or repeated.
- Redirect to 16'h0040 while ready toggles → two invalid cycles, then 16'hA040 / pc 16'h0040, then 16'hA041; no stale pre-redirect instruction appears.
- `RESET_PC` = 16'hFFFE, ready = 1 → pcs FFFE, FFFF, 0000, 0001 with matching data.
- `rst` asserted one cycle mid-stream with FIFO full → `instr_valid` = 0 and `imem_addr` = `RESET_PC` in the next cycle. The restart sequence matches the first scenario.
- With `IFETCH_STALL_CNT_EN`: 5 stalled cycles → `stall_cycles` = 5. Without the macro, the bench compiles with no `stall_cycles` port.
